// File: rtl/wb_arbiter_pkg.sv
// Shared helpers for the writeback arbiter: modular index arithmetic used by
// the round-robin allocator and the per-EU result buffers.
package wb_arbiter_pkg;

   // (base + step) mod modulus, for step < modulus and base < modulus
   function automatic int wrap_add(input int base, input int step, input int modulus);
      int sum;
      sum = base + step;
      return (sum >= modulus) ? sum - modulus : sum;
   endfunction

endpackage

// File: rtl/wb_buffer.sv
// Small synchronous FIFO holding completed results of one execution unit.
// The head entry is visible combinationally so a lane can load it in the pop cycle.
module wb_buffer
   import wb_arbiter_pkg::*;
#(
   parameter int Width = 8,
   parameter int Depth = 2
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [Width-1:0] wr_data,
   input  logic             pop,
   output logic [Width-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntWidth = $clog2(Depth + 1);

   logic [Width-1:0]    mem [Depth];
   logic [PtrWidth-1:0] wr_ptr_reg;
   logic [PtrWidth-1:0] rd_ptr_reg;
   logic [CntWidth-1:0] count_reg;
   logic                do_push;
   logic                do_pop;

   assign full    = (count_reg == CntWidth'(Depth));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= PtrWidth'(wrap_add(int'(wr_ptr_reg), 1, Depth));
         end
         if (do_pop) begin
            rd_ptr_reg <= PtrWidth'(wrap_add(int'(rd_ptr_reg), 1, Depth));
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + CntWidth'(1);
         end else if (!do_push && do_pop) begin
            count_reg <= count_reg - CntWidth'(1);
         end
      end
   end

   // Storage is not reset: stale slots are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results per execution unit and drains them
// round-robin onto registered writeback lanes, reloading a lane in its drain cycle.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NumEus         = 4,
   parameter int WritebackWidth = 2,
   parameter int BufDepth       = 2,
   parameter int NumTags        = 8,
   parameter int NumWarps       = 8,
   parameter int WarpWidth      = 32,
   parameter int RegIdxWidth    = 6,
   parameter int RegWidth       = 32,
   localparam int TagWidth      = $clog2(NumTags),
   localparam int WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
   localparam int IidWidth      = TagWidth + WidWidth,
   localparam int EuIdxWidth    = (NumEus > 1) ? $clog2(NumEus) : 1
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_i,
   input  logic [NumEus-1:0]                                    eu_valid_i,
   output logic [NumEus-1:0]                                    eu_ready_o,
   input  logic [NumEus-1:0][IidWidth-1:0]                      eu_tag_i,
   input  logic [NumEus-1:0][RegIdxWidth-1:0]                   eu_dst_i,
   input  logic [NumEus-1:0][WarpWidth-1:0]                     eu_act_mask_i,
   input  logic [NumEus-1:0][WarpWidth-1:0][RegWidth-1:0]       eu_data_i,
   output logic [WritebackWidth-1:0]                            wb_valid_o,
   input  logic [WritebackWidth-1:0]                            wb_ready_i,
   output logic [WritebackWidth-1:0][IidWidth-1:0]              wb_tag_o,
   output logic [WritebackWidth-1:0][RegIdxWidth-1:0]           wb_dst_o,
   output logic [WritebackWidth-1:0][WarpWidth-1:0]             wb_act_mask_o,
   output logic [WritebackWidth-1:0][WarpWidth-1:0][RegWidth-1:0] wb_data_o,
   output logic                                                 idle_o
);

   typedef struct packed {
      logic [IidWidth-1:0]                    tag;
      logic [RegIdxWidth-1:0]                 dst;
      logic [WarpWidth-1:0]                   act_mask;
      logic [WarpWidth-1:0][RegWidth-1:0]     data;
   } entry_t;

   typedef logic [EuIdxWidth-1:0] eu_idx_t;

   entry_t                    head [NumEus];
   logic [NumEus-1:0]         full;
   logic [NumEus-1:0]         empty;
   logic [NumEus-1:0]         pop;

   entry_t                    lane_reg [WritebackWidth];
   logic                      lane_valid_reg [WritebackWidth];
   logic [WritebackWidth-1:0] lane_free;
   logic [WritebackWidth-1:0] lane_load;
   logic [WritebackWidth-1:0] avail;
   eu_idx_t                   lane_src [WritebackWidth];
   eu_idx_t                   rr_ptr_reg;
   eu_idx_t                   rr_ptr_next;
   eu_idx_t                   cand;
   logic                      found;

   genvar gi;
   generate
      for (gi = 0; gi < NumEus; gi++) begin : g_eu
         entry_t wr_entry;

         assign wr_entry = '{tag:      eu_tag_i[gi],
                             dst:      eu_dst_i[gi],
                             act_mask: eu_act_mask_i[gi],
                             data:     eu_data_i[gi]};

         wb_buffer #(
            .Width ($bits(entry_t)),
            .Depth (BufDepth)
         ) u_buf (
            .clk     (clk_i),
            .srst    (rst_i),
            .push    (eu_valid_i[gi]),
            .wr_data (wr_entry),
            .pop     (pop[gi]),
            .rd_data (head[gi]),
            .full    (full[gi]),
            .empty   (empty[gi])
         );

         assign eu_ready_o[gi] = !full[gi];
      end
   endgenerate

   // Walk buffers from rr_ptr; the n-th non-empty one takes the n-th free lane.
   always_comb begin
      pop         = '0;
      lane_load   = '0;
      avail       = lane_free;
      rr_ptr_next = rr_ptr_reg;
      cand        = '0;
      found       = 1'b0;
      for (int l = 0; l < WritebackWidth; l++) begin
         lane_src[l] = '0;
      end
      for (int k = 0; k < NumEus; k++) begin
         cand  = eu_idx_t'(wrap_add(int'(rr_ptr_reg), k, NumEus));
         found = 1'b0;
         if (!empty[cand]) begin
            for (int l = 0; l < WritebackWidth; l++) begin
               if (!found && avail[l]) begin
                  avail[l]     = 1'b0;
                  found        = 1'b1;
                  lane_load[l] = 1'b1;
                  lane_src[l]  = cand;
               end
            end
         end
         if (found) begin
            pop[cand]   = 1'b1;
            rr_ptr_next = eu_idx_t'(wrap_add(int'(cand), 1, NumEus));
         end
      end
   end

   generate
      for (gi = 0; gi < WritebackWidth; gi++) begin : g_lane
         assign lane_free[gi] = !lane_valid_reg[gi] || wb_ready_i[gi];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               lane_valid_reg[gi] <= 1'b0;
               lane_reg[gi]       <= '0;
            end else if (lane_load[gi]) begin
               lane_valid_reg[gi] <= 1'b1;
               lane_reg[gi]       <= head[lane_src[gi]];
            end else if (wb_ready_i[gi]) begin
               lane_valid_reg[gi] <= 1'b0;
            end
         end

         assign wb_valid_o[gi]    = lane_valid_reg[gi];
         assign wb_tag_o[gi]      = lane_reg[gi].tag;
         assign wb_dst_o[gi]      = lane_reg[gi].dst;
         assign wb_act_mask_o[gi] = lane_reg[gi].act_mask;
         assign wb_data_o[gi]     = lane_reg[gi].data;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_reg <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   assign idle_o = (&empty) && !(|wb_valid_o);

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed checks of wb_arbiter against a queue-based model
// of per-EU buffers, rotating buffer scan and lane pairing.
module tb_wb_arbiter;

   localparam int NumEus = 4;
   localparam int Ww     = 2;
   localparam int Depth  = 2;
   localparam int WarpW  = 32;
   localparam int RegIdx = 6;
   localparam int RegW   = 32;
   localparam int IidW   = 6;

   typedef struct packed {
      logic [IidW-1:0]               tag;
      logic [RegIdx-1:0]             dst;
      logic [WarpW-1:0]              mask;
      logic [WarpW-1:0][RegW-1:0]    data;
   } ent_t;

   logic                                   clk = 1'b0;
   logic                                   rst;
   logic [NumEus-1:0]                      eu_valid;
   logic [NumEus-1:0]                      eu_ready;
   logic [NumEus-1:0][IidW-1:0]            eu_tag;
   logic [NumEus-1:0][RegIdx-1:0]          eu_dst;
   logic [NumEus-1:0][WarpW-1:0]           eu_mask;
   logic [NumEus-1:0][WarpW-1:0][RegW-1:0] eu_data;
   logic [Ww-1:0]                          wb_valid;
   logic [Ww-1:0]                          wb_ready;
   logic [Ww-1:0][IidW-1:0]                wb_tag;
   logic [Ww-1:0][RegIdx-1:0]              wb_dst;
   logic [Ww-1:0][WarpW-1:0]               wb_mask;
   logic [Ww-1:0][WarpW-1:0][RegW-1:0]     wb_data;
   logic                                   idle;

   int   total = 0;
   int   bad = 0;

   ent_t q [NumEus][$];
   bit   m_valid [Ww];
   ent_t m_lane [Ww];
   int   m_rr;
   logic [RegIdx-1:0] exp2 [$];
   logic [RegIdx-1:0] acc_log [$];

   always #5 clk = ~clk;

   wb_arbiter #(
      .NumEus(NumEus), .WritebackWidth(Ww), .BufDepth(Depth), .NumTags(8),
      .NumWarps(8), .WarpWidth(WarpW), .RegIdxWidth(RegIdx), .RegWidth(RegW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .eu_valid_i(eu_valid), .eu_ready_o(eu_ready), .eu_tag_i(eu_tag),
      .eu_dst_i(eu_dst), .eu_act_mask_i(eu_mask), .eu_data_i(eu_data),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_tag_o(wb_tag),
      .wb_dst_o(wb_dst), .wb_act_mask_o(wb_mask), .wb_data_o(wb_data),
      .idle_o(idle)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_payload(input int e);
      eu_tag[e]  = IidW'($urandom);
      eu_dst[e]  = RegIdx'($urandom);
      eu_mask[e] = ($urandom_range(0, 7) == 0) ? '0 : WarpW'($urandom);
      for (int t = 0; t < WarpW; t++) eu_data[e][t] = $urandom;
   endtask

   // Reference: lanes accepted this cycle free up; the n-th non-empty buffer in
   // rotated order from m_rr fills the n-th free lane; then accepted pushes append.
   task automatic model_step();
      bit rdy [NumEus];
      bit fr [Ww];
      int li;
      int last;
      if (rst) begin
         for (int e = 0; e < NumEus; e++) q[e].delete();
         for (int l = 0; l < Ww; l++) begin
            m_valid[l] = 1'b0;
            m_lane[l]  = '0;
         end
         m_rr = 0;
         return;
      end
      for (int e = 0; e < NumEus; e++) rdy[e] = (q[e].size() < Depth);
      for (int l = 0; l < Ww; l++) begin
         fr[l] = !m_valid[l] || wb_ready[l];
         if (m_valid[l] && wb_ready[l]) m_valid[l] = 1'b0;
      end
      li = 0;
      last = -1;
      for (int k = 0; k < NumEus; k++) begin
         int e;
         e = (m_rr + k) % NumEus;
         if (q[e].size() > 0) begin
            while (li < Ww && !fr[li]) li++;
            if (li < Ww) begin
               m_lane[li]  = q[e].pop_front();
               m_valid[li] = 1'b1;
               li++;
               last = e;
            end
         end
      end
      if (last >= 0) m_rr = (last + 1) % NumEus;
      for (int e = 0; e < NumEus; e++) begin
         if (eu_valid[e] && rdy[e]) begin
            q[e].push_back('{tag: eu_tag[e], dst: eu_dst[e], mask: eu_mask[e], data: eu_data[e]});
            if (e == 2) exp2.push_back(eu_dst[e]);
         end
      end
   endtask

   task automatic compare_all();
      logic [NumEus-1:0] exp_rdy;
      bit exp_idle;
      exp_idle = 1'b1;
      for (int l = 0; l < Ww; l++) begin
         check_eq($sformatf("lane%0d_valid", l), 64'(wb_valid[l]), 64'(m_valid[l]));
         if (m_valid[l]) begin
            exp_idle = 1'b0;
            check_eq($sformatf("lane%0d_tag", l), 64'(wb_tag[l]), 64'(m_lane[l].tag));
            check_eq($sformatf("lane%0d_dst", l), 64'(wb_dst[l]), 64'(m_lane[l].dst));
            check_eq($sformatf("lane%0d_mask", l), 64'(wb_mask[l]), 64'(m_lane[l].mask));
            check_eq($sformatf("lane%0d_data0", l), 64'(wb_data[l][0]), 64'(m_lane[l].data[0]));
            check_eq($sformatf("lane%0d_data_all", l), 64'(wb_data[l] === m_lane[l].data), 64'd1);
         end
      end
      for (int e = 0; e < NumEus; e++) begin
         exp_rdy[e] = (q[e].size() < Depth);
         if (q[e].size() > 0) exp_idle = 1'b0;
      end
      check_eq("eu_ready", 64'(eu_ready), 64'(exp_rdy));
      check_eq("idle", 64'(idle), 64'(exp_idle));
   endtask

   // Inputs are already set (at a negedge); advance one clock and compare.
   task automatic do_cycle();
      for (int l = 0; l < Ww; l++) begin
         if (wb_valid[l] === 1'b1 && wb_ready[l] && !rst) acc_log.push_back(wb_dst[l]);
      end
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_state();
      check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
      check_eq("rst_eu_ready", 64'(eu_ready), 64'hF);
      check_eq("rst_idle", 64'(idle), 64'd1);
      check_eq("rst_tag0", 64'(wb_tag[0]), 64'd0);
      check_eq("rst_data0", 64'(wb_data[0][0]), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      eu_valid = '0;
      do_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int prev_eu;
      int budget;
      logic [RegIdx-1:0] snap0, snap1;
      rst = 1'b1;
      eu_valid = '0;
      wb_ready = '1;
      eu_tag = '0;
      eu_dst = '0;
      eu_mask = '0;
      eu_data = '0;
      do_reset();
      do_reset();
      check_reset_state();

      // single result from EU1
      eu_valid = 4'b0010;
      eu_tag[1] = 6'h13;
      eu_dst[1] = 6'd5;
      eu_mask[1] = 32'hFFFF_FFFF;
      eu_data[1] = '0;
      eu_data[1][0] = 32'hA5;
      do_cycle();
      check_eq("single_idle_c1", 64'(idle), 64'd0);
      check_eq("single_valid_c1", 64'(wb_valid), 64'd0);
      eu_valid = '0;
      do_cycle();
      check_eq("single_lane0_valid", 64'(wb_valid[0]), 64'd1);
      check_eq("single_lane1_valid", 64'(wb_valid[1]), 64'd0);
      check_eq("single_tag", 64'(wb_tag[0]), 64'h13);
      check_eq("single_dst", 64'(wb_dst[0]), 64'd5);
      check_eq("single_mask", 64'(wb_mask[0]), 64'hFFFF_FFFF);
      check_eq("single_data", 64'(wb_data[0][0]), 64'hA5);
      check_eq("single_idle_c2", 64'(idle), 64'd0);
      do_cycle();
      check_eq("single_idle_after", 64'(idle), 64'd1);

      // burst from all four EUs
      do_reset();
      eu_valid = '1;
      for (int e = 0; e < NumEus; e++) begin
         rand_payload(e);
         eu_tag[e] = IidW'(8 + e);
      end
      do_cycle();
      eu_valid = '0;
      do_cycle();
      check_eq("burst_c2_lane0", 64'(wb_tag[0]), 64'd8);
      check_eq("burst_c2_lane1", 64'(wb_tag[1]), 64'd9);
      do_cycle();
      check_eq("burst_c3_lane0", 64'(wb_tag[0]), 64'd10);
      check_eq("burst_c3_lane1", 64'(wb_tag[1]), 64'd11);
      do_cycle();
      eu_valid = 4'b1001;
      do_cycle();
      eu_valid = '0;
      do_cycle();
      check_eq("burst_rr_zero", 64'(wb_tag[0]), 64'd8);
      do_cycle();
      do_cycle();

      // fairness with a single live lane: lane1 parked on EU1 entries
      do_reset();
      wb_ready = '0;
      eu_valid = 4'b0010;
      rand_payload(1);
      do_cycle();
      rand_payload(1);
      do_cycle();
      eu_valid = '0;
      do_cycle();
      do_cycle();
      wb_ready = 2'b01;
      prev_eu = -1;
      for (int c = 0; c < 30; c++) begin
         eu_valid = 4'b1001;
         rand_payload(0);
         rand_payload(3);
         eu_tag[0] = IidW'((c % 8) * 8 + 0);
         eu_tag[3] = IidW'((c % 8) * 8 + 3);
         do_cycle();
         if (wb_valid[0] === 1'b1) begin
            if (prev_eu >= 0) check_eq("fair_no_repeat", 64'(int'(wb_tag[0][2:0]) == prev_eu), 64'd0);
            prev_eu = int'(wb_tag[0][2:0]);
         end
      end
      eu_valid = '0;
      wb_ready = '1;
      for (int c = 0; c < 6; c++) do_cycle();

      // backpressure on all lanes while EU2 pushes every cycle
      do_reset();
      exp2.delete();
      acc_log.delete();
      wb_ready = '0;
      for (int c = 0; c < 6; c++) begin
         eu_valid = 4'b0100;
         rand_payload(2);
         eu_dst[2] = RegIdx'(c + 1);
         do_cycle();
      end
      snap0 = wb_dst[0];
      snap1 = wb_dst[1];
      for (int c = 6; c < 8; c++) begin
         rand_payload(2);
         eu_dst[2] = RegIdx'(c + 1);
         do_cycle();
      end
      check_eq("bp_stable0", 64'(wb_dst[0]), 64'(snap0));
      check_eq("bp_stable1", 64'(wb_dst[1]), 64'(snap1));
      check_eq("bp_ready2_low", 64'(eu_ready[2]), 64'd0);
      check_eq("bp_accepted", 64'(exp2.size()), 64'd4);
      eu_valid = '0;
      wb_ready = '1;
      budget = 20;
      while (idle !== 1'b1 && budget > 0) begin
         do_cycle();
         budget--;
      end
      check_eq("bp_drain_timeout", 64'(budget > 0), 64'd1);
      check_eq("bp_drain_count", 64'(acc_log.size()), 64'(exp2.size()));
      for (int i = 0; i < acc_log.size() && i < exp2.size(); i++) begin
         check_eq($sformatf("bp_order%0d", i), 64'(acc_log[i]), 64'(exp2[i]));
         check_eq($sformatf("bp_seq%0d", i), 64'(acc_log[i]), 64'(i + 1));
      end

      // reset while buffers are full and lanes are valid
      wb_ready = '0;
      for (int c = 0; c < 6; c++) begin
         eu_valid = '1;
         for (int e = 0; e < NumEus; e++) rand_payload(e);
         do_cycle();
      end
      do_reset();
      check_reset_state();
      wb_ready = '1;
      for (int c = 0; c < 4; c++) do_cycle();

      // drain and reload on lane0 in one cycle
      wb_ready = '0;
      for (int c = 0; c < 3; c++) begin
         eu_valid = 4'b0001;
         rand_payload(0);
         eu_dst[0] = RegIdx'(6'h31 + c);
         do_cycle();
      end
      eu_valid = '0;
      do_cycle();
      wb_ready = 2'b01;
      do_cycle();
      check_eq("reload_valid", 64'(wb_valid[0]), 64'd1);
      check_eq("reload_dst", 64'(wb_dst[0]), 64'h33);
      wb_ready = '1;
      for (int c = 0; c < 4; c++) do_cycle();

      // randomized traffic with occasional reset
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         eu_valid = NumEus'($urandom);
         wb_ready = Ww'($urandom);
         for (int e = 0; e < NumEus; e++) rand_payload(e);
         do_cycle();
      end
      rst = 1'b0;
      eu_valid = '0;
      wb_ready = '1;
      for (int c = 0; c < 8; c++) do_cycle();
      check_eq("final_idle", 64'(idle), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Collects completed results from `NumEus` execution units and forwards them on `WritebackWidth` registered writeback lanes. Each lane drives the register-file write port and the per-warp dispatchers' `eu_valid`/`eu_tag` inputs, so this block is the transmitting end of the dispatcher's writeback interface. Every execution unit has a small buffer. Buffers are drained round-robin into free lanes, so a stalled lane never blocks the execution units while buffer space remains.

## Interface
- `NumEus`, 4: number of execution units feeding writeback.
- `WritebackWidth`, 2: number of output lanes. Must satisfy 1 ≤ `WritebackWidth` ≤ `NumEus`.
- `BufDepth`, 2: entries per execution-unit buffer. Must be ≥ 1.
- `NumTags`, 8: inflight tags per warp.
- `NumWarps`, 8: warps per compute unit.
- `WarpWidth`, 32: threads per warp.
- `RegIdxWidth`, 6: destination register index width.
- `RegWidth`, 32: data bits per thread.
- Derived, do not override:
  - `TagWidth` = `$clog2(NumTags)`.
  - `WidWidth` = `NumWarps>1 ? $clog2(NumWarps) : 1`.
  - `iid_t` = `TagWidth+WidWidth` bits, laid out as `{tag, wid}` with wid in the LSBs.
  - `EuIdxWidth` = `NumEus>1 ? $clog2(NumEus) : 1`.

Ports:
- `clk_i` in 1: clock. One clock domain; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `eu_valid_i` in `NumEus`: result valid, one bit per execution unit.
- `eu_ready_o` out `NumEus`: buffer not full, one bit per execution unit.
- `eu_tag_i` in `NumEus`×iid_t: instruction id of the result.
- `eu_dst_i` in `NumEus`×`RegIdxWidth`: destination register.
- `eu_act_mask_i` in `NumEus`×`WarpWidth`: thread write mask.
- `eu_data_i` in `NumEus`×`WarpWidth`×`RegWidth`: result data.
- `wb_valid_o` out `WritebackWidth`: lane holds a result.
- `wb_ready_i` in `WritebackWidth`: register-file port accepts the lane.
- `wb_tag_o`, `wb_dst_o`, `wb_act_mask_o`, `wb_data_o` out, per lane: lane payload.
- `idle_o` out 1: all buffers and all lanes empty.

## Operation
- Input handshake: an entry is pushed into EU e's buffer when `eu_valid_i[e] && eu_ready_o[e]`.
  - `eu_ready_o[e]` = buffer e not full, registered state only. There is no combinational path from `wb_ready_i`.
  - Payload is passed through unmodified, including an all-zero act mask.
- Lane l is free when `!wb_valid_o[l]`, or when `wb_valid_o[l] && wb_ready_i[l]` (drain and reload in the same cycle).
- Selection each cycle:
  - Scan non-empty buffers from `rr_ptr` upward, wrapping at `NumEus`.
  - Assign them to free lanes in ascending lane order.
  - At most one entry per EU per cycle; each EU goes to at most one lane.
  - A granted buffer is popped, and the lane register loads its head entry.
- `rr_ptr` update:
  - If at least one grant occurred, `rr_ptr` becomes (last granted EU + 1) mod `NumEus`.
  - Otherwise `rr_ptr` is unchanged.
- Simultaneous push and pop on the same buffer is allowed, including when the buffer is full: that cycle's `eu_ready_o` is still 0, because it depends on registered state only.
- Ordering:
  - When all `wb_ready_i` are high, results from the same EU leave in push order.
  - Across lanes under backpressure, no ordering is guaranteed. Dispatcher scoreboarding prevents write-after-write hazards.
- Reset with `rst_i` high at a clock edge:
  - All buffers are emptied and all `wb_valid_o` cleared.
  - `rr_ptr` is set to 0.
  - In-flight payloads are discarded.
- Reset values of outputs: `wb_valid_o` = 0, `eu_ready_o` = all 1 after the reset edge, `idle_o` = 1, payload outputs = 0.

## Timing
- An input accepted in cycle t is in its buffer at t+1 and is eligible for selection in t+1.
- It appears on a lane in t+2, provided a lane is free and it wins arbitration. Minimum latency is 2 cycles.
- Throughput: up to `WritebackWidth` results per cycle, limited by one result per EU per cycle.
- A stalled lane (`wb_valid_o[l] && !wb_ready_i[l]`) must hold its payload stable until accepted.
- When a buffer is full, `eu_ready_o` is low in the following cycle. At a sustained rate of one entry per cycle with no drains, `BufDepth` accepts occur before ready falls.
- `idle_o` is combinational from registered state only.

## Structure
- `bgpu_pkg`: no new shared types. The entry struct (tag, dst, act_mask, data) is parameter-dependent and stays local to this module.
- Sub-module `wb_buffer`: a parameterised synchronous FIFO (depth `BufDepth`, active-high synchronous reset) with full, empty, push and pop, and no fall-through. It is instantiated once per EU.
- The round-robin lane allocator and the lane registers live in `wb_arbiter` itself.

## Test plan
- Single result, default parameters. EU1 presents tag 0x13, dst 5, mask 0xFFFF_FFFF, data 0xA5 in cycle 0. Required response:
  - In cycle 2, lane0 is valid with exactly that payload and lane1 is invalid.
  - `idle_o` is 0 in cycles 1–2 and returns to 1 after the drain.
- Burst, `WritebackWidth`=2, `wb_ready_i` tied high. All four EUs are valid in cycle 0. Required response:
  - Cycle 2: lanes carry EU0 and EU1.
  - Cycle 3: lanes carry EU2 and EU3.
  - `rr_ptr` ends at 0.
- Fairness, `WritebackWidth`=1. EU0 and EU3 are continuously valid with distinct tags. Required response: lane0 alternates EU0, EU3, EU0, …, with no EU winning twice in a row.
- Backpressure. `wb_ready_i`=0 on all lanes while EU2 pushes every cycle. Required response:
  - Lane payloads stay stable.
  - `eu_ready_o[2]` falls after buffer full with `BufDepth`=2.
  - After `wb_ready_i` is raised, all entries drain in push order and none are lost or duplicated.
- Reset mid-operation. `rst_i` is asserted for 1 cycle while buffers are full and lanes are valid. Required response: in the next cycle, `wb_valid_o` = 0, `eu_ready_o` = all 1, `idle_o` = 1, and no stale entry ever appears afterward.
- Drain and reload. Lane0 is valid and is accepted in the same cycle that EU0 has an entry. Required response: lane0 presents the new entry in the next cycle, with no bubble.
